// File: rtl/song_player_ctrl.sv
// Auto-play sequencer for the song ROM: walks addresses, times each note from its
// ROM duration, inserts a silent gap between notes and flags the natural end of song.
module song_player_ctrl #(
  parameter int ADDR_W     = 9,
  parameter int DUR_W      = 32,
  parameter int GAP_CYCLES = 50_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic [3:0]        song_sel,
  input  logic [3:0]        rom_note,
  input  logic [DUR_W-1:0]  rom_duration,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [3:0]        rom_song,
  output logic [3:0]        note_out,
  output logic              note_active,
  output logic              playing,
  output logic              song_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    PLAY  = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam bit                HAS_GAP   = (GAP_CYCLES > 0);
  localparam logic [DUR_W-1:0]  GAP_LOAD  = HAS_GAP ? DUR_W'(GAP_CYCLES - 1) : '0;

  state_t           state;
  logic [DUR_W-1:0] dur_cnt;
  logic [DUR_W-1:0] gap_cnt;

  // Counters are loaded with length-1 and run down to zero, so a note of
  // duration D occupies exactly D cycles in PLAY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rom_addr    <= '0;
      rom_song    <= '0;
      note_out    <= '0;
      note_active <= 1'b0;
      playing     <= 1'b0;
      song_done   <= 1'b0;
      dur_cnt     <= '0;
      gap_cnt     <= '0;
    end else begin
      song_done <= 1'b0;
      if (stop) begin
        state       <= IDLE;
        rom_addr    <= '0;
        note_out    <= '0;
        note_active <= 1'b0;
        playing     <= 1'b0;
        dur_cnt     <= '0;
        gap_cnt     <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              rom_song <= song_sel;
              rom_addr <= '0;
              playing  <= 1'b1;
              state    <= FETCH;
            end
          end
          FETCH: begin
            if (rom_duration == '0) begin
              song_done <= 1'b1;
              state     <= DONE;
            end else begin
              dur_cnt     <= rom_duration - 1'b1;
              note_out    <= rom_note;
              note_active <= (rom_note != 4'd0);
              state       <= PLAY;
            end
          end
          PLAY: begin
            if (pause) begin
              note_active <= 1'b0;
            end else if (dur_cnt == '0) begin
              note_out    <= '0;
              note_active <= 1'b0;
              if (HAS_GAP) begin
                gap_cnt <= GAP_LOAD;
                state   <= GAP;
              end else if (rom_addr == LAST_ADDR) begin
                song_done <= 1'b1;
                state     <= DONE;
              end else begin
                rom_addr <= rom_addr + 1'b1;
                state    <= FETCH;
              end
            end else begin
              dur_cnt     <= dur_cnt - 1'b1;
              note_active <= (note_out != 4'd0);
            end
          end
          GAP: begin
            if (!pause) begin
              if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
              end else if (rom_addr == LAST_ADDR) begin
                song_done <= 1'b1;
                state     <= DONE;
              end else begin
                rom_addr <= rom_addr + 1'b1;
                state    <= FETCH;
              end
            end
          end
          DONE: begin
            rom_addr <= '0;
            playing  <= 1'b0;
            state    <= IDLE;
          end
          default: begin
            state   <= IDLE;
            playing <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
